// File: rtl/io_input_unit.sv
// Input unit for the IN instruction: stalls the core until a debounced button press,
// then captures the synchronised switch inputs into a 32-bit word.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no request in service
// ARM        | request seen; waiting for the button to read released
// WAIT_PRESS | button released; waiting for a debounced press event
// GRANT      | switches captured; stall lifted for exactly this cycle
module io_input_unit #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int BUTTON_ACTIVE_LOW = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        IO_Enable,
  input  logic        IO_Selection,
  input  logic        Button,
  input  logic [17:0] Raw_Input,
  output logic        Halt,
  output logic [31:0] Data_In,
  output logic        Input_Valid
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic BTN_INV = (BUTTON_ACTIVE_LOW != 0);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ARM        = 2'd1;
  localparam logic [1:0] WAIT_PRESS = 2'd2;
  localparam logic [1:0] GRANT      = 2'd3;

  logic          req;
  logic          btn_s1, btn_s2;
  logic [17:0]   raw_s1, raw_s2;
  logic          pressed_s;
  logic [CW-1:0] cnt;
  logic          db_level, db_prev;
  logic          press_evt;
  logic [1:0]    state, state_nxt;
  logic [17:0]   data_q;
  logic          capture;

  assign req       = IO_Enable & ~IO_Selection;
  assign pressed_s = btn_s2 ^ BTN_INV;
  assign press_evt = db_level & ~db_prev;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      raw_s1 <= '0;
      raw_s2 <= '0;
    end else begin
      btn_s1 <= Button;
      btn_s2 <= btn_s1;
      raw_s1 <= Raw_Input;
      raw_s2 <= raw_s1;
    end
  end

  // A level change is accepted only after it has differed for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt      <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      db_prev <= db_level;
      if (pressed_s == db_level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db_level <= pressed_s;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = ARM;
      end
      ARM: begin
        if (!req)           state_nxt = IDLE;
        else if (!db_level) state_nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (press_evt) begin
          state_nxt = GRANT;
          capture   = 1'b1;
        end
      end
      GRANT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (capture) data_q <= raw_s2;
    end
  end

  // Combinational so the core stalls in the same cycle the IN instruction appears.
  assign Halt        = ~Reset & req & (state != GRANT);
  assign Input_Valid = (state == GRANT);
  assign Data_In     = {14'b0, data_q};

endmodule

// File: tb/tb_io_input_unit.sv
// Directed bench for io_input_unit with DEBOUNCE_CYCLES=4 and an active-low button.
module tb_io_input_unit;

  logic        Clock;
  logic        Reset;
  logic        IO_Enable;
  logic        IO_Selection;
  logic        Button;
  logic [17:0] Raw_Input;
  logic        Halt;
  logic [31:0] Data_In;
  logic        Input_Valid;

  int total = 0;
  int bad   = 0;

  io_input_unit #(
    .DEBOUNCE_CYCLES  (4),
    .BUTTON_ACTIVE_LOW(1)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .IO_Enable   (IO_Enable),
    .IO_Selection(IO_Selection),
    .Button      (Button),
    .Raw_Input   (Raw_Input),
    .Halt        (Halt),
    .Data_In     (Data_In),
    .Input_Valid (Input_Valid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Watches n cycles in which no grant may occur; stall and data must stay put.
  task automatic idle_watch(input string tag, input int n, input logic halt_exp,
                            input logic [31:0] data_exp);
    for (int i = 0; i < n; i++) begin
      step(1);
      chk({tag, "_valid"}, {31'b0, Input_Valid}, 32'd0);
      chk({tag, "_halt"},  {31'b0, Halt},        {31'b0, halt_exp});
      chk({tag, "_data"},  Data_In,              data_exp);
    end
  endtask

  initial begin
    Reset        = 1'b1;
    IO_Enable    = 1'b1;
    IO_Selection = 1'b0;
    Button       = 1'b1;
    Raw_Input    = 18'h0;

    // 1: reset values, then stall appears the moment reset drops
    step(3);
    chk("rst_halt",  {31'b0, Halt},        32'd0);
    chk("rst_data",  Data_In,              32'd0);
    chk("rst_valid", {31'b0, Input_Valid}, 32'd0);
    Reset = 1'b0;
    #1;
    chk("rel_halt", {31'b0, Halt}, 32'd1);
    idle_watch("pre_press", 5, 1'b1, 32'd0);

    // 2: clean press, grant exactly 7 edges after the pin edge
    Raw_Input = 18'h2A5A5;
    Button    = 1'b0;
    step(6);
    chk("p1_early_valid", {31'b0, Input_Valid}, 32'd0);
    chk("p1_early_halt",  {31'b0, Halt},        32'd1);
    chk("p1_early_data",  Data_In,              32'd0);
    step(1);
    chk("p1_grant_valid", {31'b0, Input_Valid}, 32'd1);
    chk("p1_grant_halt",  {31'b0, Halt},        32'd0);
    chk("p1_grant_data",  Data_In,              32'h0002A5A5);
    step(1);
    chk("p1_after_valid", {31'b0, Input_Valid}, 32'd0);
    chk("p1_after_halt",  {31'b0, Halt},        32'd1);

    // 3/5: second request with the button still held must not be granted
    idle_watch("held", 20, 1'b1, 32'h0002A5A5);
    Raw_Input = 18'h01234;
    Button    = 1'b1;
    idle_watch("release", 8, 1'b1, 32'h0002A5A5);
    Button = 1'b0;
    step(6);
    chk("p2_early_valid", {31'b0, Input_Valid}, 32'd0);
    step(1);
    chk("p2_grant_valid", {31'b0, Input_Valid}, 32'd1);
    chk("p2_grant_halt",  {31'b0, Halt},        32'd0);
    chk("p2_grant_data",  Data_In,              32'h00001234);
    step(1);
    chk("p2_after_valid", {31'b0, Input_Valid}, 32'd0);

    // 4: three-cycle glitch while waiting is filtered
    Button = 1'b1;
    idle_watch("release2", 10, 1'b1, 32'h00001234);
    Button = 1'b0;
    step(3);
    Button = 1'b1;
    idle_watch("glitch", 15, 1'b1, 32'h00001234);

    // output requests are ignored
    IO_Selection = 1'b1;
    #1;
    chk("out_req_halt", {31'b0, Halt}, 32'd0);
    step(1);
    IO_Selection = 1'b0;
    #1;
    chk("out_back_halt", {31'b0, Halt}, 32'd1);
    step(3);

    // 6: request withdrawn while waiting; a press then must not capture
    IO_Enable = 1'b0;
    #1;
    chk("wd_halt", {31'b0, Halt}, 32'd0);
    Raw_Input = 18'h3FFFF;
    Button    = 1'b0;
    idle_watch("withdrawn", 10, 1'b0, 32'h00001234);
    Button = 1'b1;
    idle_watch("wd_release", 8, 1'b0, 32'h00001234);
    IO_Enable = 1'b1;
    #1;
    chk("wd_reissue_halt", {31'b0, Halt}, 32'd1);
    step(2);
    Button = 1'b0;
    step(6);
    chk("p3_early_valid", {31'b0, Input_Valid}, 32'd0);
    step(1);
    chk("p3_grant_valid", {31'b0, Input_Valid}, 32'd1);
    chk("p3_grant_data",  Data_In,              32'h0003FFFF);
    step(1);
    chk("p3_after_halt",  {31'b0, Halt},        32'd1);

    // async reset mid-ARM (button still held) acts immediately
    step(3);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_halt",  {31'b0, Halt},        32'd0);
    chk("arst_data",  Data_In,              32'd0);
    chk("arst_valid", {31'b0, Input_Valid}, 32'd0);
    step(3);
    Reset = 1'b0;

    // held button is re-qualified by the debouncer after reset
    step(4);
    chk("post_rst_early_valid", {31'b0, Input_Valid}, 32'd0);
    chk("post_rst_early_halt",  {31'b0, Halt},        32'd1);
    step(1);
    chk("post_rst_grant_valid", {31'b0, Input_Valid}, 32'd1);
    chk("post_rst_grant_data",  Data_In,              32'h0003FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
